if_fetch_unit: RTL and testbench

- Instruction fetch stage. Generates the PC, runs the instruction-memory request/acknowledge handshake and presents fetched {pc, instruction} pairs to the IF/ID pipeline register.
- Honours the IF stall bit of the pipeline stall bus and redirects from EX on taken branches and jumps.
- A one-entry skid buffer prevents loss or duplication of instructions under stall.

---
 rtl/if_fetch_unit_pkg.sv | 17 +
 rtl/if_fetch_unit_skid_buf.sv | 86 ++++++++
 rtl/if_fetch_unit.sv | 83 ++++++++
 tb/tb_if_fetch_unit.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch stage.
// Bus widths, the NOP encoding and the fetch FSM state type.
package if_fetch_unit_pkg;

    localparam int INS_ADDR_W   = 32;
    localparam int DATA_W       = 32;
    localparam int STALL_BUS_W  = 6;
    localparam int IF_STALL_BIT = 0;

    localparam logic [DATA_W-1:0] NOP = 32'h0000_0013;

    typedef enum logic {
        FETCH   = 1'b0,
        DISCARD = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit_skid_buf.sv
// Output register plus a single skid entry for the fetch stage.
// Holds the presented instruction under stall and catches one extra fetch.
module if_skid_buf
    import if_fetch_unit_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [INS_ADDR_W-1:0] pc_i,
    input  logic [DATA_W-1:0]     ins_i,
    input  logic                  consume_i,
    input  logic                  clear_i,
    output logic [INS_ADDR_W-1:0] pc_o,
    output logic [DATA_W-1:0]     ins_o,
    output logic                  valid_o,
    output logic                  full_o
);

    logic [INS_ADDR_W-1:0] out_pc_q, out_pc_d;
    logic [DATA_W-1:0]     out_ins_q, out_ins_d;
    logic                  out_vld_q, out_vld_d;
    logic [INS_ADDR_W-1:0] skid_pc_q, skid_pc_d;
    logic [DATA_W-1:0]     skid_ins_q, skid_ins_d;
    logic                  skid_full_q, skid_full_d;

    // Next-state: clear wins, then refill a free output slot, else park in skid.
    always_comb begin
        out_pc_d    = out_pc_q;
        out_ins_d   = out_ins_q;
        out_vld_d   = out_vld_q;
        skid_pc_d   = skid_pc_q;
        skid_ins_d  = skid_ins_q;
        skid_full_d = skid_full_q;
        if (clear_i) begin
            out_vld_d   = 1'b0;
            out_ins_d   = NOP;
            skid_full_d = 1'b0;
        end else if (consume_i || !out_vld_q) begin
            if (skid_full_q) begin
                out_pc_d    = skid_pc_q;
                out_ins_d   = skid_ins_q;
                out_vld_d   = 1'b1;
                skid_full_d = load_i;
                if (load_i) begin
                    skid_pc_d  = pc_i;
                    skid_ins_d = ins_i;
                end
            end else if (load_i) begin
                out_pc_d  = pc_i;
                out_ins_d = ins_i;
                out_vld_d = 1'b1;
            end else begin
                out_vld_d = 1'b0;
            end
        end else if (load_i) begin
            skid_pc_d   = pc_i;
            skid_ins_d  = ins_i;
            skid_full_d = 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_pc_q    <= '0;
            out_ins_q   <= NOP;
            out_vld_q   <= 1'b0;
            skid_pc_q   <= '0;
            skid_ins_q  <= NOP;
            skid_full_q <= 1'b0;
        end else begin
            out_pc_q    <= out_pc_d;
            out_ins_q   <= out_ins_d;
            out_vld_q   <= out_vld_d;
            skid_pc_q   <= skid_pc_d;
            skid_ins_q  <= skid_ins_d;
            skid_full_q <= skid_full_d;
        end
    end

    assign pc_o    = out_pc_q;
    assign ins_o   = out_ins_q;
    assign valid_o = out_vld_q;
    assign full_o  = skid_full_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC generation, imem handshake and redirect.
// A redirect during an outstanding request waits out the ack in DISCARD.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          STALL_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STALL_W-1:0]    stall_i,
    input  logic                  redirect_i,
    input  logic [INS_ADDR_W-1:0] redirect_pc_i,
    output logic                  imem_req_o,
    output logic [INS_ADDR_W-1:0] imem_addr_o,
    input  logic                  imem_ack_i,
    input  logic [DATA_W-1:0]     imem_rdata_i,
    output logic [INS_ADDR_W-1:0] pc_o,
    output logic [DATA_W-1:0]     ins_o,
    output logic                  ins_valid_o
);

    localparam logic [INS_ADDR_W-1:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

    fetch_state_e          state_q;
    logic [INS_ADDR_W-1:0] fetch_pc_q;
    logic [INS_ADDR_W-1:0] target_q;
    logic [INS_ADDR_W-1:0] redir_pc;
    logic                  skid_full;
    logic                  req;
    logic                  ack_ok;
    logic                  consume;
    logic                  load;
    logic                  unused_bits;

    assign redir_pc    = {redirect_pc_i[31:2], 2'b00};
    assign req         = !rst && ((state_q == DISCARD) || !skid_full);
    assign ack_ok      = req && imem_ack_i;
    assign consume     = ins_valid_o && !stall_i[IF_STALL_BIT];
    assign load        = ack_ok && (state_q == FETCH) && !redirect_i;
    assign imem_req_o  = req;
    assign imem_addr_o = fetch_pc_q;
    assign unused_bits = ^{stall_i[STALL_W-1:1], redirect_pc_i[1:0]};

    // Fetch FSM: PC advance on ack, redirect handling and discard of stale data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC_AL;
            target_q   <= RESET_PC_AL;
        end else if (redirect_i) begin
            if (req && !imem_ack_i) begin
                state_q  <= DISCARD;
                target_q <= redir_pc;
            end else begin
                state_q    <= FETCH;
                fetch_pc_q <= redir_pc;
            end
        end else if (ack_ok) begin
            if (state_q == DISCARD) begin
                state_q    <= FETCH;
                fetch_pc_q <= target_q;
            end else begin
                fetch_pc_q <= fetch_pc_q + 32'd4;
            end
        end
    end

    if_skid_buf u_skid (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load),
        .pc_i      (fetch_pc_q),
        .ins_i     (imem_rdata_i),
        .consume_i (consume),
        .clear_i   (redirect_i),
        .pc_o      (pc_o),
        .ins_o     (ins_o),
        .valid_o   (ins_valid_o),
        .full_o    (skid_full)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a wait-state memory model.
// Second instance exercises a high RESET_PC and address wrap.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;
    logic [31:0] pc;
    logic [31:0] ins;
    logic        valid;

    logic        rst2;
    logic [5:0]  stall2;
    logic        redirect2;
    logic [31:0] redirect_pc2;
    logic        req2;
    logic [31:0] addr2;
    logic        ack2;
    logic [31:0] rdata2;
    logic [31:0] pc2;
    logic [31:0] ins2;
    logic        valid2;

    int wait_n;
    int wcnt;
    int checks;
    int errors;

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .STALL_W(6)) u_dut (
        .clk(clk), .rst(rst), .stall_i(stall), .redirect_i(redirect),
        .redirect_pc_i(redirect_pc), .imem_req_o(req), .imem_addr_o(addr),
        .imem_ack_i(ack), .imem_rdata_i(rdata), .pc_o(pc), .ins_o(ins),
        .ins_valid_o(valid)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .STALL_W(6)) u_dut2 (
        .clk(clk), .rst(rst2), .stall_i(stall2), .redirect_i(redirect2),
        .redirect_pc_i(redirect_pc2), .imem_req_o(req2), .imem_addr_o(addr2),
        .imem_ack_i(ack2), .imem_rdata_i(rdata2), .pc_o(pc2), .ins_o(ins2),
        .ins_valid_o(valid2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        ack    = req && (wcnt == wait_n);
        rdata  = addr ^ 32'h5A00_0000;
        ack2   = req2;
        rdata2 = addr2 ^ 32'h5A00_0000;
    end

    always @(posedge clk) begin
        if (!req || ack) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int w);
        rst = 1'b1;
        stall = '0;
        redirect = 1'b0;
        redirect_pc = '0;
        wait_n = w;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (req !== 1'b0 || valid !== 1'b0 || ins !== 32'h13 || pc !== 32'h0) begin
            errors++;
            $display("FAIL reset: req=%b valid=%b ins=%h pc=%h want 0 0 00000013 0",
                     req, valid, ins, pc);
        end
    endtask

    task automatic test_zero_wait();
        logic [31:0] e;
        do_reset(0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c <= 4) begin
                e = 32'(4 * (c - 1));
                checks++;
                if (req !== 1'b1 || addr !== e) begin
                    errors++;
                    $display("FAIL zw_addr c%0d: req=%b addr=%h want 1 %h", c, req, addr, e);
                end
            end
            if (c >= 2) begin
                e = 32'(4 * (c - 2));
                checks++;
                if (valid !== 1'b1 || pc !== e || ins !== (e ^ 32'h5A00_0000)) begin
                    errors++;
                    $display("FAIL zw_out c%0d: v=%b pc=%h ins=%h want 1 %h %h",
                             c, valid, pc, ins, e, e ^ 32'h5A00_0000);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_wait2();
        logic [31:0] e;
        logic        ve;
        do_reset(2);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            e = 32'(4 * ((c - 1) / 3));
            checks++;
            if (req !== 1'b1 || addr !== e) begin
                errors++;
                $display("FAIL w2_addr c%0d: req=%b addr=%h want 1 %h", c, req, addr, e);
            end
            ve = (c > 1) && ((c - 1) % 3 == 0);
            checks++;
            if (valid !== ve) begin
                errors++;
                $display("FAIL w2_valid c%0d: valid=%b want %b", c, valid, ve);
            end
            if (ve) begin
                e = 32'(4 * ((c - 1) / 3 - 1));
                checks++;
                if (pc !== e) begin
                    errors++;
                    $display("FAIL w2_pc c%0d: pc=%h want %h", c, pc, e);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_stall();
        do_reset(0);
        for (int c = 1; c <= 9; c++) begin
            stall = {5'h15, (c >= 3 && c <= 7 - 1)};
            @(negedge clk);
            if ((c >= 3 && c <= 6) || c == 7) begin
                checks++;
                if (valid !== 1'b1 || pc !== 32'h4) begin
                    errors++;
                    $display("FAIL st_hold c%0d: v=%b pc=%h want 1 00000004", c, valid, pc);
                end
            end
            if (c >= 4 && c <= 7) begin
                checks++;
                if (req !== 1'b0) begin
                    errors++;
                    $display("FAIL st_req c%0d: req=%b want 0", c, req);
                end
            end
            if (c == 8) begin
                checks++;
                if (valid !== 1'b1 || pc !== 32'h8 || ins !== 32'h5A00_0008 ||
                    req !== 1'b1 || addr !== 32'hC) begin
                    errors++;
                    $display("FAIL st_skid: v=%b pc=%h ins=%h req=%b addr=%h want 1 8 5a000008 1 c",
                             valid, pc, ins, req, addr);
                end
            end
            if (c == 9) begin
                checks++;
                if (valid !== 1'b1 || pc !== 32'hC) begin
                    errors++;
                    $display("FAIL st_next: v=%b pc=%h want 1 0000000c", valid, pc);
                end
            end
            next_cycle();
        end
        stall = '0;
    endtask

    task automatic test_redirect();
        do_reset(2);
        redirect_pc = 32'h100;
        for (int c = 1; c <= 16; c++) begin
            redirect = (c == 11);
            @(negedge clk);
            checks++;
            if (valid === 1'b1 && pc === 32'hC) begin
                errors++;
                $display("FAIL rd_drop c%0d: pc=%h valid, want never 0000000c", c, pc);
            end
            if (c == 11 || c == 12) begin
                checks++;
                if (req !== 1'b1 || addr !== 32'hC) begin
                    errors++;
                    $display("FAIL rd_hold c%0d: req=%b addr=%h want 1 c", c, req, addr);
                end
            end
            if (c == 13) begin
                checks++;
                if (req !== 1'b1 || addr !== 32'h100) begin
                    errors++;
                    $display("FAIL rd_tgt: req=%b addr=%h want 1 100", req, addr);
                end
            end
            if (c >= 11 && c <= 15) begin
                checks++;
                if (valid !== 1'b0) begin
                    errors++;
                    $display("FAIL rd_gap c%0d: valid=%b want 0", c, valid);
                end
            end
            if (c == 16) begin
                checks++;
                if (valid !== 1'b1 || pc !== 32'h100 || ins !== 32'h5A00_0100) begin
                    errors++;
                    $display("FAIL rd_first: v=%b pc=%h ins=%h want 1 100 5a000100",
                             valid, pc, ins);
                end
            end
            next_cycle();
        end
        redirect = 1'b0;
    endtask

    task automatic test_redirect_full();
        do_reset(0);
        redirect_pc = 32'h203;
        for (int c = 1; c <= 6; c++) begin
            stall = {5'h0, (c == 3 || c == 4)};
            redirect = (c == 4);
            @(negedge clk);
            if (c == 4) begin
                checks++;
                if (req !== 1'b0 || valid !== 1'b1 || pc !== 32'h4) begin
                    errors++;
                    $display("FAIL rf_full: req=%b v=%b pc=%h want 0 1 4", req, valid, pc);
                end
            end
            if (c == 5) begin
                checks++;
                if (valid !== 1'b0 || ins !== 32'h13 || req !== 1'b1 || addr !== 32'h200) begin
                    errors++;
                    $display("FAIL rf_clear: v=%b ins=%h req=%b addr=%h want 0 13 1 200",
                             valid, ins, req, addr);
                end
            end
            if (c == 6) begin
                checks++;
                if (valid !== 1'b1 || pc !== 32'h200 || ins !== 32'h5A00_0200) begin
                    errors++;
                    $display("FAIL rf_first: v=%b pc=%h ins=%h want 1 200 5a000200",
                             valid, pc, ins);
                end
            end
            next_cycle();
        end
        stall = '0;
        redirect = 1'b0;
    endtask

    task automatic test_wrap_reset();
        for (int c = 1; c <= 6; c++) begin
            rst2 = (c == 4);
            @(negedge clk);
            if (c == 1) begin
                checks++;
                if (req2 !== 1'b1 || addr2 !== 32'hFFFF_FFF8) begin
                    errors++;
                    $display("FAIL wr_a0: req=%b addr=%h want 1 fffffff8", req2, addr2);
                end
            end
            if (c == 2) begin
                checks++;
                if (addr2 !== 32'hFFFF_FFFC || valid2 !== 1'b1 || pc2 !== 32'hFFFF_FFF8) begin
                    errors++;
                    $display("FAIL wr_a1: addr=%h v=%b pc=%h want fffffffc 1 fffffff8",
                             addr2, valid2, pc2);
                end
            end
            if (c == 3) begin
                checks++;
                if (addr2 !== 32'h0 || pc2 !== 32'hFFFF_FFFC) begin
                    errors++;
                    $display("FAIL wr_wrap: addr=%h pc=%h want 0 fffffffc", addr2, pc2);
                end
            end
            if (c == 4) begin
                checks++;
                if (req2 !== 1'b0) begin
                    errors++;
                    $display("FAIL wr_abandon: req=%b want 0", req2);
                end
            end
            if (c == 5) begin
                checks++;
                if (valid2 !== 1'b0 || ins2 !== 32'h13 || pc2 !== 32'h0 ||
                    req2 !== 1'b1 || addr2 !== 32'hFFFF_FFF8) begin
                    errors++;
                    $display("FAIL wr_rst: v=%b ins=%h pc=%h req=%b addr=%h want 0 13 0 1 fffffff8",
                             valid2, ins2, pc2, req2, addr2);
                end
            end
            if (c == 6) begin
                checks++;
                if (valid2 !== 1'b1 || pc2 !== 32'hFFFF_FFF8 || ins2 !== 32'hA5FF_FFF8) begin
                    errors++;
                    $display("FAIL wr_restart: v=%b pc=%h ins=%h want 1 fffffff8 a5fffff8",
                             valid2, pc2, ins2);
                end
            end
            next_cycle();
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        stall        = '0;
        redirect     = 1'b0;
        redirect_pc  = '0;
        wait_n       = 0;
        rst2         = 1'b1;
        stall2       = '0;
        redirect2    = 1'b0;
        redirect_pc2 = '0;
        test_reset();
        test_zero_wait();
        test_wait2();
        test_stall();
        test_redirect();
        test_redirect_full();
        test_wrap_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
